// File: rtl/shreg_deser.sv
// rtl/shreg_deser.sv - LSB-first serial-to-parallel receiver with valid/ready handshakes
// Shifts WIDTH accepted bits in from the top so bit i lands in parout[i], then holds the word.
module shreg_deser #(
  parameter int WIDTH = 6,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             start,
  input  logic             serin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] parout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  assign sin_ready = (state == COLLECT);
  assign busy      = (state == COLLECT);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      parout <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else if (init) begin
      state  <= IDLE;
      parout <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= COLLECT;
            parout <= '0;
            cnt    <= '0;
            err    <= 1'b0;
          end
        end
        COLLECT: begin
          if (sin_valid) begin
            parout <= {serin, parout[WIDTH-1:1]};
            if (cnt == LAST_CNT) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // A restart clears err even if a stray bit arrives on the same edge.
          if (sin_valid) err <= 1'b1;
          if (out_ready) begin
            if (start) begin
              state  <= COLLECT;
              parout <= '0;
              cnt    <= '0;
              err    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_deser.sv
// tb/tb_shreg_deser.sv - self-checking bench for shreg_deser against a bit-list reference model
module tb_shreg_deser;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init = 1'b0;
  logic         start = 1'b0;
  logic         serin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sin_ready;
  logic [W-1:0] parout;
  logic         out_valid;
  logic         busy;
  logic         err;

  int errors = 0;
  int checks = 0;

  // Reference model: which phase we are in, the bits received so far, sticky error.
  bit           m_col;
  bit           m_hold;
  int           m_bits;
  logic [W-1:0] m_word;
  bit           m_err;

  shreg_deser #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .init(init), .start(start), .serin(serin),
    .sin_valid(sin_valid), .sin_ready(sin_ready), .parout(parout),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_col = 0; m_hold = 0; m_bits = 0; m_word = '0; m_err = 0;
  endtask

  task automatic model_begin();
    m_col = 1; m_hold = 0; m_bits = 0; m_word = '0; m_err = 0;
  endtask

  task automatic model_update(input bit i_init, input bit st, input bit si,
                              input bit sv, input bit ordy);
    if (i_init) model_clear();
    else if (m_col) begin
      if (sv) begin
        m_word[m_bits] = si;
        m_bits++;
        if (m_bits == W) begin m_col = 0; m_hold = 1; end
      end
    end else if (m_hold) begin
      if (sv) m_err = 1;
      if (ordy) begin
        m_hold = 0;
        if (st) model_begin();
      end
    end else if (st) model_begin();
  endtask

  // While collecting, the received bits sit in the top m_bits positions of parout.
  function automatic logic [W+3:0] exp_vec();
    logic [W-1:0] p;
    p = m_word << (W - m_bits);
    return {p, m_hold, m_col, m_col, m_err};
  endfunction

  task automatic step(input bit i_init, input bit st, input bit si,
                      input bit sv, input bit ordy);
    init = i_init; start = st; serin = si; sin_valid = sv; out_ready = ordy;
    @(posedge clk);
    model_update(i_init, st, si, sv, ordy);
    @(negedge clk);
    init = 0; start = 0; sin_valid = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    model_clear();
    checks++;
    if ({parout, out_valid, sin_ready, busy, err} !== {{W{1'b0}}, 4'b0000}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {parout, out_valid, sin_ready, busy, err});
    end
    rst = 1;
    step(0, 0, 0, 1, 1);
    checks++;
    if ({parout, out_valid, sin_ready, busy, err} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", {parout, out_valid, sin_ready, busy, err}, exp_vec());
    end
  endtask

  task automatic test_basic();
    bit [5:0] bits = 6'b001101;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < W; i++) begin
      step(0, 0, bits[i], 1, 0);
      checks++;
      if ({parout, out_valid, sin_ready, busy, err} !== exp_vec()) begin
        errors++;
        $display("FAIL basic_bit%0d: got %h want %h", i, {parout, out_valid, sin_ready, busy, err}, exp_vec());
      end
    end
    checks++;
    if (parout !== 6'h0D || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_word: got parout=%h valid=%b want 0d/1", parout, out_valid);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_stall();
    bit [5:0] bits = 6'b001101;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < W; i++) begin
      step(0, 0, bits[i], 1, 0);
      if (i == 1) begin
        for (int g = 0; g < 3; g++) begin
          step(0, 0, 1, 0, 0);
          checks++;
          if ({parout, out_valid, sin_ready, busy, err} !== exp_vec()) begin
            errors++;
            $display("FAIL stall_gap%0d: got %h want %h", g, {parout, out_valid, sin_ready, busy, err}, exp_vec());
          end
        end
      end
    end
    checks++;
    if (parout !== 6'h0D || out_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL stall_word: got parout=%h valid=%b err=%b want 0d/1/0", parout, out_valid, err);
    end
  endtask

  task automatic test_hold_err();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 1, 0);
      checks++;
      if ({parout, out_valid, sin_ready, busy, err} !== exp_vec() || parout !== 6'h0D || err !== 1'b1) begin
        errors++;
        $display("FAIL hold_err%0d: got %h want %h", i, {parout, out_valid, sin_ready, busy, err}, exp_vec());
      end
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    checks++;
    if ({parout, out_valid, sin_ready, busy, err} !== exp_vec() || err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle_err: got %h want %h", {parout, out_valid, sin_ready, busy, err}, exp_vec());
    end
  endtask

  task automatic test_restart();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < W; i++) step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1);
    checks++;
    if ({parout, out_valid, sin_ready, busy, err} !== exp_vec() || busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_collect: got %h want %h", {parout, out_valid, sin_ready, busy, err}, exp_vec());
    end
    for (int i = 0; i < W; i++) step(0, 0, 1, 1, 0);
    checks++;
    if (parout !== 6'h3F || out_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_word: got parout=%h valid=%b err=%b want 3f/1/0", parout, out_valid, err);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    logic [W-1:0] w;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    #2 rst = 0;
    #1;
    model_clear();
    checks++;
    if ({parout, out_valid, sin_ready, busy, err} !== {{W{1'b0}}, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {parout, out_valid, sin_ready, busy, err});
    end
    @(negedge clk);
    rst = 1;
    step(0, 0, 1, 1, 1);
    checks++;
    if ({parout, out_valid, sin_ready, busy, err} !== exp_vec()) begin
      errors++;
      $display("FAIL async_idle: got %h want %h", {parout, out_valid, sin_ready, busy, err}, exp_vec());
    end
    w = W'($urandom);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < W; i++) step(0, 0, w[i], 1, 0);
    checks++;
    if (parout !== w || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_word: got parout=%h valid=%b want %h/1", parout, out_valid, w);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_init();
    step(1, 1, 0, 0, 0);
    checks++;
    if ({parout, out_valid, sin_ready, busy, err} !== {{W{1'b0}}, 4'b0000}) begin
      errors++;
      $display("FAIL init_idle: got %h want 0", {parout, out_valid, sin_ready, busy, err});
    end
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 1);
      checks++;
      if ({parout, out_valid, sin_ready, busy, err} !== {{W{1'b0}}, 4'b0000}) begin
        errors++;
        $display("FAIL init_collect%0d: got %h want 0", i, {parout, out_valid, sin_ready, busy, err});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           $urandom_range(0, 9) < 7, 1'($urandom));
      checks++;
      if ({parout, out_valid, sin_ready, busy, err} !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h want %h", i, {parout, out_valid, sin_ready, busy, err}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hold_err();
    test_restart();
    test_async_reset();
    test_init();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
